// File: rtl/cpld_link_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : cpld_link_sched_if
// Description : Requester-side bundle of the CPLD link scheduler: request
//               flags, two display images, grant pulses and current owner.
// Revision    : 1.0  initial release
// ============================================================================
interface cpld_link_sched_if;
    logic [1:0]  req;
    logic [23:0] img0;
    logic [23:0] img1;
    logic [1:0]  ack;
    logic        owner;

    modport master (
        output req,
        output img0,
        output img1,
        input  ack,
        input  owner
    );

    modport slave (
        input  req,
        input  img0,
        input  img1,
        output ack,
        output owner
    );
endinterface
`default_nettype wire

// File: rtl/cpld_link_sched.sv
`default_nettype none
// ============================================================================
// Module      : cpld_link_sched
// Description : 16-bit frame sequencer for the serial CPLD link plus a
//               two-requester, hold-limited arbiter choosing each frame image.
// Revision    : 1.0  initial release
// ============================================================================
module cpld_link_sched #(
    parameter int CLK_FREQ_HZ = 100000000,
    parameter int SCLK_HZ     = 1600,
    parameter int MAX_HOLD    = 8
) (
    input  wire              clk,
    input  wire              rst,
    cpld_link_sched_if.slave bus,
    output logic [7:0]       sw_data,
    output logic [4:0]       navsw,
    output logic             rx_valid,
    output logic             cpld_clk,
    output logic             cpld_load,
    output logic             cpld_mosi,
    input  wire              cpld_miso
);

    localparam int                   c_div      = CLK_FREQ_HZ / (2 * SCLK_HZ);
    localparam int                   c_div_w    = (c_div > 2) ? $clog2(c_div) : 1;
    localparam logic [c_div_w-1:0]   c_div_last = c_div_w'(c_div - 1);
    localparam logic [7:0]           c_hold_lim = 8'(MAX_HOLD - 1);
    localparam logic [3:0]           c_last_bit = 4'd15;

    logic [c_div_w-1:0] r_div;
    logic               r_cclk;
    logic               r_miso_s;
    logic [15:0]        r_shr;
    logic [3:0]         r_bit_cnt;
    logic               r_owner;
    logic [7:0]         r_hold;
    logic [23:0]        r_img;
    logic [1:0]         r_ack;
    logic [7:0]         r_sw;
    logic [4:0]         r_nav;
    logic               r_rx;
    logic               r_mosi;

    logic               w_tick;
    logic               w_rise;
    logic               w_fall;
    logic               w_last_bit;
    logic               w_req_own;
    logic               w_req_oth;
    logic               w_grant;
    logic               w_owner_nxt;
    logic [7:0]         w_hold_nxt;
    logic [23:0]        w_img_nxt;
    logic [1:0]         w_ack_nxt;
    logic               w_dsel_nxt;
    logic [15:0]        w_frame_word;

    assign w_tick     = (r_div == '0);
    assign w_rise     = w_tick & ~r_cclk;
    assign w_fall     = w_tick & r_cclk;
    assign w_last_bit = (r_bit_cnt == c_last_bit);

    assign w_req_own  = bus.req[r_owner];
    assign w_req_oth  = bus.req[~r_owner];

    // The current owner keeps the link until the other side has waited
    // through MAX_HOLD consecutive frames.
    always_comb begin
        w_grant     = 1'b0;
        w_owner_nxt = r_owner;
        w_hold_nxt  = r_hold;
        if (w_req_own && (!w_req_oth || (r_hold < c_hold_lim))) begin
            w_grant    = 1'b1;
            w_hold_nxt = (r_hold == 8'hFF) ? r_hold : r_hold + 8'd1;
        end else if (w_req_oth) begin
            w_grant     = 1'b1;
            w_owner_nxt = ~r_owner;
            w_hold_nxt  = 8'd0;
        end
    end

    always_comb begin
        w_img_nxt = r_img;
        w_ack_nxt = 2'b00;
        if (w_grant) begin
            w_img_nxt = w_owner_nxt ? bus.img1 : bus.img0;
            w_ack_nxt = w_owner_nxt ? 2'b10 : 2'b01;
        end
    end

    // Display digit for the next frame follows the select bit just received.
    assign w_dsel_nxt   = r_shr[14];
    assign w_frame_word = {(w_dsel_nxt ? w_img_nxt[15:8] : w_img_nxt[23:16]),
                           w_img_nxt[7:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div     <= c_div_last;
            r_cclk    <= 1'b0;
            r_miso_s  <= 1'b0;
            r_shr     <= 16'd0;
            r_bit_cnt <= 4'd0;
            r_owner   <= 1'b0;
            r_hold    <= 8'd0;
            r_img     <= 24'd0;
            r_ack     <= 2'b00;
            r_sw      <= 8'd0;
            r_nav     <= 5'd0;
            r_rx      <= 1'b0;
            r_mosi    <= 1'b0;
        end else begin
            r_ack  <= 2'b00;
            r_rx   <= 1'b0;
            r_mosi <= r_shr[0];

            if (w_tick) begin
                r_div  <= c_div_last;
                r_cclk <= ~r_cclk;
            end else begin
                r_div  <= r_div - c_div_w'(1);
            end

            if (w_rise) begin
                r_miso_s <= cpld_miso;
            end

            if (w_fall) begin
                if (!w_last_bit) begin
                    r_shr     <= {r_miso_s, r_shr[15:1]};
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                end else begin
                    r_sw      <= r_shr[8:1];
                    r_nav     <= r_shr[13:9];
                    r_rx      <= 1'b1;
                    r_owner   <= w_owner_nxt;
                    r_hold    <= w_hold_nxt;
                    r_img     <= w_img_nxt;
                    r_ack     <= w_ack_nxt;
                    r_shr     <= w_frame_word;
                    r_bit_cnt <= 4'd0;
                end
            end
        end
    end

    assign bus.ack   = r_ack;
    assign bus.owner = r_owner;
    assign sw_data   = r_sw;
    assign navsw     = r_nav;
    assign rx_valid  = r_rx;
    assign cpld_clk  = r_cclk;
    assign cpld_load = w_last_bit;
    assign cpld_mosi = r_mosi;

endmodule
`default_nettype wire

// File: tb/tb_cpld_link_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpld_link_sched
// Description : Randomized bench for cpld_link_sched with a frame-level model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_cpld_link_sched;

    localparam int c_frame = 128;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] sw_data;
    logic [4:0] navsw;
    logic       rx_valid;
    logic       cpld_clk;
    logic       cpld_load;
    logic       cpld_mosi;
    logic       cpld_miso = 1'b0;

    always #5 clk = ~clk;

    cpld_link_sched_if bus();

    cpld_link_sched #(
        .CLK_FREQ_HZ (32),
        .SCLK_HZ     (4),
        .MAX_HOLD    (8)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .sw_data   (sw_data),
        .navsw     (navsw),
        .rx_valid  (rx_valid),
        .cpld_clk  (cpld_clk),
        .cpld_load (cpld_load),
        .cpld_mosi (cpld_mosi),
        .cpld_miso (cpld_miso)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    bit          chk_en   = 1'b0;
    logic [15:0] w_cur    = 16'd0;
    logic [15:0] w_fixed  = 16'd0;
    bit          w_rand   = 1'b0;

    bit          m_owner;
    int          m_hold;
    logic [23:0] m_img;
    logic [15:0] m_word;
    logic [7:0]  m_sw;
    logic [4:0]  m_nav;
    logic [1:0]  e_ack;
    bit          e_rx, e_cclk, e_load, e_mosi;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Frame-level reference: what the link must show after each clk edge,
    // counted from reset release.
    task automatic frame_end();
        bit o, p, grant;
        o = m_owner;
        p = ~m_owner;
        grant = 1'b0;
        if (bus.req[o] && (!bus.req[p] || m_hold < 7)) begin
            grant = 1'b1;
            if (m_hold < 255) m_hold++;
        end else if (bus.req[p]) begin
            m_owner = p;
            m_hold  = 0;
            grant   = 1'b1;
        end
        if (grant) begin
            m_img = m_owner ? bus.img1 : bus.img0;
            e_ack = m_owner ? 2'b10 : 2'b01;
        end
        m_sw   = w_cur[8:1];
        m_nav  = w_cur[13:9];
        e_rx   = 1'b1;
        m_word = {(w_cur[14] ? m_img[15:8] : m_img[23:16]), m_img[7:0]};
    endtask

    always @(posedge clk) begin
        if (rst) begin
            cyc = 0; m_owner = 1'b0; m_hold = 0; m_img = 24'd0; m_word = 16'd0;
            m_sw = 8'd0; m_nav = 5'd0; e_ack = 2'b00; e_rx = 1'b0;
            e_cclk = 1'b0; e_load = 1'b0; e_mosi = 1'b0;
        end else begin
            cyc++;
            e_mosi = m_word[((cyc - 1) % c_frame) / 8];
            e_cclk = ((cyc / 4) % 2) == 1;
            e_load = (cyc % c_frame) >= 120;
            e_ack  = 2'b00;
            e_rx   = 1'b0;
            if (cyc % c_frame == 0) frame_end();
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("ack",       {30'd0, bus.ack},  {30'd0, e_ack});
            check("owner",     {31'd0, bus.owner}, {31'd0, m_owner});
            check("sw_data",   {24'd0, sw_data},  {24'd0, m_sw});
            check("navsw",     {27'd0, navsw},    {27'd0, m_nav});
            check("rx_valid",  {31'd0, rx_valid}, {31'd0, e_rx});
            check("cpld_clk",  {31'd0, cpld_clk}, {31'd0, e_cclk});
            check("cpld_load", {31'd0, cpld_load}, {31'd0, e_load});
            check("cpld_mosi", {31'd0, cpld_mosi}, {31'd0, e_mosi});
        end
    end

    // CPLD side: word bit j is presented for the j-th rise of the frame.
    always @(negedge clk) begin
        if (cyc % c_frame == 0) w_cur = w_rand ? 16'($urandom) : w_fixed;
        if ((cyc + 1) % 8 == 4) cpld_miso = w_cur[((cyc + 5) / 8) % 16];
    end

    task automatic run_to(input int tgt, input int mode);
        int guard;
        guard = 0;
        while (cyc != tgt) begin
            @(negedge clk);
            guard++;
            if (guard > 1000) begin
                $display("FAIL run_to: cycle %0d never reached %0d", cyc, tgt);
                $fatal(1, "bench timeout");
            end
            if (mode >= 1 && $urandom_range(15) == 0) bus.img0 = 24'($urandom);
            if (mode >= 1 && $urandom_range(15) == 0) bus.img1 = 24'($urandom);
            if (mode == 2 && $urandom_range(7) == 0)  bus.req  = 2'($urandom);
        end
    endtask

    initial begin
        logic [15:0] mw;
        bit          own_q[$];
        int          lc, first, run_len, ack_seen, t;

        bus.req  = 2'b01;
        bus.img0 = 24'h005AC3;
        bus.img1 = 24'h123456;
        w_fixed  = 16'h4000;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        rst    = 1'b0;
        check("rst_ack",   {30'd0, bus.ack}, 32'd0);
        check("rst_owner", {31'd0, bus.owner}, 32'd0);

        run_to(3, 0);
        check("cclk_before_rise", {31'd0, cpld_clk}, 32'd0);
        run_to(4, 0);
        check("cclk_first_rise", {31'd0, cpld_clk}, 32'd1);
        lc = 0;
        for (int c = 5; c <= 128; c++) begin
            run_to(c, 0);
            if (cpld_load) lc++;
        end
        check("load_cycles", lc, 8);
        check("first_ack",   {30'd0, bus.ack}, 32'd1);
        check("first_rx",    {31'd0, rx_valid}, 32'd1);

        for (int k = 0; k < 16; k++) begin
            run_to(129 + 8 * k, 0);
            mw[k] = cpld_mosi;
        end
        check("mosi_word", {16'd0, mw}, 32'h5AC3);

        // Both requesters competing, images churning between frame ends.
        bus.req = 2'b11;
        w_fixed = 16'h2AA5;
        for (int f = 0; f < 20; f++) begin
            run_to((cyc / c_frame + 1) * c_frame, 1);
            own_q.push_back(bus.owner);
            if (f == 1) begin
                check("sw_2aa5",  {24'd0, sw_data}, 32'h52);
                check("nav_2aa5", {27'd0, navsw},   32'h15);
            end
        end
        first = -1;
        for (int i = own_q.size() - 1; i >= 0; i--) if (own_q[i]) first = i;
        check("first_switch_frame", first, 6);
        run_len = 0;
        if (first >= 0)
            for (int i = first; i < own_q.size() && own_q[i]; i++) run_len++;
        check("owner1_run", run_len, 8);

        // No requests: nothing granted, previous owner and image stay.
        bus.req  = 2'b00;
        w_rand   = 1'b1;
        ack_seen = 0;
        for (int c = 0; c < 3 * c_frame; c++) begin
            run_to(cyc + 1, 1);
            if (bus.ack != 2'b00) ack_seen++;
        end
        check("idle_acks",  ack_seen, 0);
        check("idle_owner", {31'd0, bus.owner}, 32'd0);

        for (int f = 0; f < 15; f++) run_to((cyc / c_frame + 1) * c_frame, 2);

        // Abort in the middle of bit 7.
        t = (cyc / c_frame) * c_frame + 60;
        if (t <= cyc) t += c_frame;
        run_to(t, 0);
        rst = 1'b1;
        @(negedge clk);
        check("abort_ack",   {30'd0, bus.ack},   32'd0);
        check("abort_owner", {31'd0, bus.owner}, 32'd0);
        check("abort_sw",    {24'd0, sw_data},   32'd0);
        check("abort_nav",   {27'd0, navsw},     32'd0);
        check("abort_rx",    {31'd0, rx_valid},  32'd0);
        check("abort_cclk",  {31'd0, cpld_clk},  32'd0);
        check("abort_load",  {31'd0, cpld_load}, 32'd0);
        check("abort_mosi",  {31'd0, cpld_mosi}, 32'd0);
        bus.req = 2'b11;
        @(negedge clk);
        rst = 1'b0;
        run_to(127, 0);
        check("post_abort_no_ack", {30'd0, bus.ack}, 32'd0);
        run_to(128, 0);
        check("post_abort_ack", {30'd0, bus.ack}, 32'd1);
        run_to(256, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
